// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and instruction memory (slave).
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetcher: IDLE -> REQ -> WAIT -> HOLD loop.
// Optional MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VEC with a trap pulse.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PCsrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] JumpTarget,
    input  logic            retire,
    pc_fetch_unit_if.master imem,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            trap
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] next_pc;
    logic [31:0]     instr_q;
    logic            take_retire;

    assign take_retire = (state == HOLD) && retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (imem.imem_req_ready) state_nxt = WAIT;
            WAIT: if (imem.imem_rsp_valid) state_nxt = HOLD;
            HOLD: if (retire)              state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        target = pc_q + XLEN'(4);
        unique case (PCsrc)
            2'b01:   target = pc_q + ImmExt;
            2'b10:   target = JumpTarget;
            default: target = pc_q + XLEN'(4);
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q;

    assign misaligned = |target[1:0];
    assign next_pc    = misaligned ? TRAP_VEC : target;

    // Pulse lands in the cycle after the retire that produced the bad target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= take_retire && misaligned;
        end
    end

    assign trap = trap_q;
`else
    assign next_pc = {target[XLEN-1:2], 2'b00};
    assign trap    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            if ((state == WAIT) && imem.imem_rsp_valid) begin
                instr_q <= imem.imem_rdata;
            end
            if (take_retire) begin
                pc_q <= next_pc;
            end
        end
    end

    assign imem.imem_req_valid = (state == REQ);
    assign imem.imem_addr      = pc_q;
    assign instr_valid         = (state == HOLD);
    assign instr               = instr_q;
    assign PC                  = pc_q;
    assign PCPlus4             = pc_q + XLEN'(4);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit; the memory responder and PC model
// live in the stimulus process, the monitor pops expectations as the DUT presents them.
module tb_pc_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCsrc;
    logic [31:0] ImmExt;
    logic [31:0] JumpTarget;
    logic        retire;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        trap;

    pc_fetch_unit_if #(.XLEN(32)) imem();

    pc_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCsrc       (PCsrc),
        .ImmExt      (ImmExt),
        .JumpTarget  (JumpTarget),
        .retire      (retire),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .trap        (trap)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          retired = 0;
    logic [31:0] addr_q[$];
    exp_t        instr_q[$];
    logic        trap_exp = 1'b0;
    logic        acc_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory-side view of the handshake: did a request get accepted at the coming edge.
    always @(negedge clk) begin
        acc_seen = rst_n && imem.imem_req_valid && imem.imem_req_ready;
    end

    logic        prev_iv = 1'b0;
    logic [31:0] last_instr = '0;
    logic [31:0] exp_pc = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_req_valid", imem.imem_req_valid, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_pc", PC, RESET_PC);
            chk("rst_instr", instr, 0);
            chk("rst_trap", trap, 0);
            last_instr = '0;
            prev_iv    = 1'b0;
        end else begin
            chk("trap", trap, trap_exp);
            if (imem.imem_req_valid) begin
                if (addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_req: got addr %h want no request", imem.imem_addr);
                end else begin
                    chk("req_addr", imem.imem_addr, addr_q[0]);
                    if (imem.imem_req_ready) void'(addr_q.pop_front());
                end
            end
            if (instr_valid && !prev_iv) begin
                if (instr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_instr: got %h want no instruction", instr);
                end else begin
                    exp_t e;
                    e = instr_q.pop_front();
                    last_instr = e.word;
                    exp_pc     = e.pc;
                    retired++;
                    chk("instr_pc", PC, exp_pc);
                    chk("pcplus4", PCPlus4, exp_pc + 32'd4);
                end
            end else if (instr_valid) begin
                chk("pc_hold", PC, exp_pc);
            end
            chk("instr_word", instr, last_instr);
            prev_iv = instr_valid;
        end
    end

    logic [31:0] model_pc;
    logic [31:0] nxt;
    logic [31:0] rsp_word;
    logic        pending, holding, rsp_taken, ret_taken, did_reset;
    int          delay, stall;

    initial begin
        rst_n = 1'b0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rdata     = '0;
        retire     = 1'b0;
        PCsrc      = 2'b00;
        ImmExt     = '0;
        JumpTarget = '0;
        model_pc   = RESET_PC;
        addr_q.push_back(RESET_PC);
        pending = 1'b0; holding = 1'b0; rsp_taken = 1'b0; ret_taken = 1'b0;
        did_reset = 1'b0; delay = 0; stall = 0; rsp_word = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            trap_exp = 1'b0;
            // Account for what the edge just passed consumed.
            if (ret_taken) begin
                case (PCsrc)
                    2'b01:   nxt = model_pc + ImmExt;
                    2'b10:   nxt = JumpTarget;
                    default: nxt = model_pc + 32'd4;
                endcase
`ifdef MISALIGN_TRAP_EN
                if (nxt % 4 != 0) begin
                    nxt      = TRAP_VEC;
                    trap_exp = 1'b1;
                end
`else
                nxt = nxt - (nxt % 4);
`endif
                model_pc = nxt;
                holding  = 1'b0;
                addr_q.push_back(nxt);
            end
            if (rsp_taken) begin
                pending = 1'b0;
                holding = 1'b1;
                instr_q.push_back('{word: rsp_word, pc: model_pc});
            end
            if (acc_seen) begin
                pending = 1'b1;
                delay   = $urandom_range(0, 3);
            end

            if (!did_reset && pending && i > 1500) begin
                did_reset = 1'b1;
                rst_n     = 1'b0;
                trap_exp  = 1'b0;
                addr_q.delete();
                instr_q.delete();
                model_pc = RESET_PC;
                addr_q.push_back(RESET_PC);
                pending = 1'b0; holding = 1'b0; rsp_taken = 1'b0; ret_taken = 1'b0;
                retire = 1'b0;
                imem.imem_rsp_valid = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                // The response to the dropped request shows up late and must be ignored.
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rdata     = $urandom;
                imem.imem_req_ready = 1'b1;
                continue;
            end

            if (stall > 0) begin
                stall--;
                imem.imem_req_ready = 1'b0;
            end else if ($urandom_range(0, 29) == 0) begin
                stall = 5;
                imem.imem_req_ready = 1'b0;
            end else begin
                imem.imem_req_ready = ($urandom_range(0, 9) < 7);
            end

            if (pending && delay == 0) begin
                rsp_word = $urandom;
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rdata     = rsp_word;
                rsp_taken = 1'b1;
            end else begin
                if (pending) delay--;
                rsp_taken = 1'b0;
                imem.imem_rsp_valid = !pending && ($urandom_range(0, 4) == 0);
                imem.imem_rdata     = $urandom;
            end

            retire = ($urandom_range(0, 2) == 0);
            PCsrc  = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: ImmExt = 32'hFFFF_FFF8;
                default: ImmExt = 32'($urandom_range(0, 127)) - 32'd64;
            endcase
            case ($urandom_range(0, 3))
                0: JumpTarget = $urandom;
                1: JumpTarget = 32'hFFFF_FFFC;
                2: JumpTarget = 32'h0000_1002;
                default: JumpTarget = 32'h0000_1000;
            endcase
            ret_taken = retire && holding;
        end

        total++;
        if (retired < 50) begin
            bad++;
            $display("FAIL progress: got %0d instructions want at least 50", retired);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
